// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment BCD scan driver.
package seg_scan_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Widest display the suppression helper can handle; designs pad up to this.
  localparam int MAX_DIG = 16;

  // True when the nibble is a code the segment decoders understand.
  function automatic logic is_bcd(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

  // Per-digit leading-zero suppress vector: bit i is set when digit i and every
  // more significant digit are zero. Digit 0 is never suppressed so a value of
  // zero still shows a single "0".
  function automatic logic [MAX_DIG-1:0] lz_mask(input logic [4*MAX_DIG-1:0] value,
                                                 input int n_dig);
    logic [MAX_DIG-1:0] mask;
    logic higher_zero;
    mask = '0;
    higher_zero = 1'b1;
    for (int i = MAX_DIG - 1; i >= 0; i--) begin
      if (i < n_dig) begin
        higher_zero = higher_zero && (value[4*i +: 4] == 4'd0);
        if (i > 0) mask[i] = higher_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer: counts clk cycles within one digit slot, flags the last cycle of
// the slot and the anti-ghosting dead time at the start of the slot.
module scan_prescaler #(
  parameter int TICK_DIV = 50000,
  parameter int DEAD_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic dead
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;

  assign tick = (div_cnt == CNT_W'(TICK_DIV - 1));
  assign dead = (div_cnt < CNT_W'(DEAD_CYC));

  // Free-running divider that wraps once per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: steps through the digits of
// a double-buffered BCD value and drives one nibble plus one digit enable per slot.
module bcd_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int TICK_DIV = 50000,
  parameter int DEAD_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [4*N_DIG-1:0] value_in,
  input  logic               lz_en,
  output logic [3:0]         bcd_out,
  output logic [N_DIG-1:0]   dig_en_n,
  output logic               blank,
  output logic               frame_done,
  output logic               load_err
);

  localparam int SLOT_W = $clog2(N_DIG);

  logic                   tick;
  logic                   dead;
  logic                   frame_end;
  logic [SLOT_W-1:0]      slot;
  logic [4*N_DIG-1:0]     active;
  logic [4*N_DIG-1:0]     shadow;
  logic                   pending;
  logic [N_DIG-1:0]       slot_onehot;
  logic [MAX_DIG-1:0]     slot_wide;
  logic [4*MAX_DIG-1:0]   act_wide;
  logic [MAX_DIG-1:0]     sup_all;
  bcd_t                   cur_nib;
  logic                   cur_sup;
  logic                   value_bad;

  scan_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .dead  (dead)
  );

  assign frame_end = tick && (slot == SLOT_W'(N_DIG - 1));

  // Advance to the next digit at the end of every slot, wrapping after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (tick) begin
      slot <= frame_end ? '0 : slot + SLOT_W'(1);
    end
  end

  // Double buffer: loads land in shadow, and only move to the displayed value at
  // a frame boundary so a frame never mixes digits from two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (frame_end && pending) active <= shadow;
      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Select the current digit's nibble, enable and suppress bit for this slot.
  always_comb begin
    slot_onehot = '0;
    cur_nib     = '0;
    for (int i = 0; i < N_DIG; i++) begin
      slot_onehot[i] = (slot == SLOT_W'(i));
      if (slot == SLOT_W'(i)) cur_nib = active[4*i +: 4];
    end
    slot_wide              = '0;
    slot_wide[N_DIG-1:0]   = slot_onehot;
    act_wide               = '0;
    act_wide[4*N_DIG-1:0]  = active;
    sup_all                = lz_mask(act_wide, N_DIG);
    cur_sup                = |(sup_all & slot_wide);
  end

  // Flag an incoming value that carries any non-BCD nibble.
  always_comb begin
    value_bad = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (!is_bcd(value_in[4*i +: 4])) value_bad = 1'b1;
    end
  end

  // Registered outputs, one cycle behind the counter state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out    <= '0;
      dig_en_n   <= '1;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      bcd_out    <= cur_nib;
      frame_done <= frame_end;
      load_err   <= load && value_bad;
      if (dead) begin
        dig_en_n <= '1;
        blank    <= 1'b1;
      end else begin
        dig_en_n <= ~slot_onehot;
        blank    <= !is_bcd(cur_nib) || (lz_en && cur_sup);
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver with a 4-digit, 8-cycle-slot setup.
module tb_bcd_scan_driver;

  localparam int N_DIG    = 4;
  localparam int TICK_DIV = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = N_DIG * TICK_DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_en_n;
  logic        blank;
  logic        frame_done;
  logic        load_err;

  typedef struct {
    logic [3:0] bcd;
    logic       blank;
    logic [3:0] dig_en_n;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  blank;
    logic        err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  logic [3:0] t1_exp[11];

  int n_checks;
  int n_errors;
  int cyc;

  bcd_scan_driver #(
    .N_DIG    (N_DIG),
    .TICK_DIV (TICK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value_in   (value_in),
    .lz_en      (lz_en),
    .bcd_out    (bcd_out),
    .dig_en_n   (dig_en_n),
    .blank      (blank),
    .frame_done (frame_done),
    .load_err   (load_err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gotoPhase(input int phase);
    while ((cyc % FRAME) != phase) step();
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic lz);
    value_in = value;
    lz_en    = lz;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic pushFrame(input logic [15:0] value, input logic [3:0] blank_vec);
    exp_t e;
    for (int i = 0; i < N_DIG; i++) begin
      e.bcd      = value[4*i +: 4];
      e.blank    = blank_vec[i];
      e.dig_en_n = ~(4'b0001 << i);
      sb_q.push_back(e);
    end
  endtask

  task automatic observeFrame(input string tag);
    exp_t cur;
    int s;
    int div;
    cur.bcd = '0;
    cur.blank = 1'b0;
    cur.dig_en_n = '1;
    gotoPhase(0);
    for (int k = 0; k < FRAME; k++) begin
      step();
      s   = cyc - 1;
      div = s % TICK_DIV;
      checkOutput({tag, " frame_done"}, 16'(frame_done), 16'((cyc % FRAME) == 0));
      if (div == 1) begin
        if (sb_q.size() == 0) begin
          checkOutput({tag, " scoreboard underrun"}, 16'(0), 16'(1));
        end else begin
          cur = sb_q.pop_front();
        end
        checkOutput({tag, " dead dig_en_n"}, 16'(dig_en_n), 16'hF);
        checkOutput({tag, " dead blank"}, 16'(blank), 16'(1));
        checkOutput({tag, " dead bcd_out"}, 16'(bcd_out), 16'(cur.bcd));
      end
      if (div == 5) begin
        checkOutput({tag, " dig_en_n"}, 16'(dig_en_n), 16'(cur.dig_en_n));
        checkOutput({tag, " blank"}, 16'(blank), 16'(cur.blank));
        checkOutput({tag, " bcd_out"}, 16'(bcd_out), 16'(cur.bcd));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = '0;
    lz_en    = 1'b0;

    vecs[0] = '{value: 16'h1234, lz: 1'b0, blank: 4'b0000, err: 1'b0};
    vecs[1] = '{value: 16'h0005, lz: 1'b1, blank: 4'b1110, err: 1'b0};
    vecs[2] = '{value: 16'h0005, lz: 1'b0, blank: 4'b0000, err: 1'b0};
    vecs[3] = '{value: 16'h00A7, lz: 1'b0, blank: 4'b0010, err: 1'b1};
    vecs[4] = '{value: 16'h0000, lz: 1'b1, blank: 4'b1110, err: 1'b0};
    vecs[5] = '{value: 16'h0102, lz: 1'b1, blank: 4'b1000, err: 1'b0};
    vecs[6] = '{value: 16'h9F09, lz: 1'b1, blank: 4'b0100, err: 1'b1};

    t1_exp = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};

    // Reset values, then the enable pattern right after release.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset bcd_out", 16'(bcd_out), 16'(0));
    checkOutput("reset dig_en_n", 16'(dig_en_n), 16'hF);
    checkOutput("reset blank", 16'(blank), 16'(1));
    checkOutput("reset frame_done", 16'(frame_done), 16'(0));
    checkOutput("reset load_err", 16'(load_err), 16'(0));
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 11; k++) begin
      step();
      checkOutput("startup dig_en_n", 16'(dig_en_n), 16'(t1_exp[k]));
    end
    pushFrame(16'h0000, 4'b0000);
    observeFrame("idle");

    // Table of loaded values, each shown from the following frame.
    for (int v = 0; v < 7; v++) begin
      gotoPhase(10);
      applyStimulus(vecs[v].value, vecs[v].lz);
      checkOutput("load_err pulse", 16'(load_err), 16'(vecs[v].err));
      step();
      checkOutput("load_err clear", 16'(load_err), 16'(0));
      pushFrame(vecs[v].value, vecs[v].blank);
      observeFrame($sformatf("vec%0d", v));
    end

    // A second load before the boundary replaces the first.
    gotoPhase(5);
    applyStimulus(16'h1111, 1'b0);
    gotoPhase(20);
    applyStimulus(16'h2222, 1'b0);
    checkOutput("overwrite load_err", 16'(load_err), 16'(0));
    pushFrame(16'h2222, 4'b0000);
    observeFrame("overwrite");

    // Load on the boundary cycle while another value is pending.
    gotoPhase(10);
    applyStimulus(16'h2222, 1'b0);
    pushFrame(16'h2222, 4'b0000);
    gotoPhase(FRAME - 1);
    applyStimulus(16'h3333, 1'b0);
    checkOutput("boundary load_err", 16'(load_err), 16'(0));
    pushFrame(16'h3333, 4'b0000);
    observeFrame("boundary first");
    observeFrame("boundary second");

    // Mid-slot reset is immediate and discards the pending value.
    gotoPhase(10);
    applyStimulus(16'h5555, 1'b0);
    gotoPhase(13);
    checkOutput("pre-reset dig_en_n", 16'(dig_en_n), 16'hD);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset dig_en_n", 16'(dig_en_n), 16'hF);
    checkOutput("async reset blank", 16'(blank), 16'(1));
    checkOutput("async reset bcd_out", 16'(bcd_out), 16'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    pushFrame(16'h0000, 4'b0000);
    observeFrame("after reset");

    checkOutput("scoreboard drained", 16'(sb_q.size()), 16'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
